// File: rtl/psum_postproc_pkg.sv
// rtl/psum_postproc_pkg.sv - shared widths, pipeline stage types and the requant/activation helper
// PSUM_POSTPROC_LEAKY_EN selects leaky activation (slope 1/8) instead of ReLU.
package psum_postproc_pkg;

    localparam int W_SIZE              = 9;
    localparam int W_CHANNEL           = 9;
    localparam int Tout                = 4;
    localparam int W_PSUM              = 20;
    localparam int W_ACC               = 32;
    localparam int W_BIAS              = 16;
    localparam int OFM_DW              = Tout * 8;
    localparam int PSUM_DEPTH          = 512;
    localparam int PSUM_AW             = 9;
    localparam int W_SHIFT             = 5;
    localparam int PSUM_POSTPROC_DELAY = 5;
    localparam int W_ADDR_FULL         = 2 * W_SIZE + 1;

    typedef struct packed {
        logic [W_SIZE-1:0]    row;
        logic [W_SIZE-1:0]    col;
        logic [W_CHANNEL-1:0] chn_out;
    } meta_t;

    typedef struct packed {
        logic                     vld;
        logic                     first;
        logic                     last;
        logic [PSUM_AW-1:0]       addr;
        logic [Tout*W_PSUM-1:0]   data;
        meta_t                    meta;
    } in_stage_t;

    typedef struct packed {
        logic                     vld;
        logic                     last;
        logic [PSUM_AW-1:0]       addr;
        logic [Tout*W_ACC-1:0]    acc;
        meta_t                    meta;
    } acc_stage_t;

    typedef struct packed {
        logic                     vld;
        logic [Tout*W_ACC-1:0]    b;
        meta_t                    meta;
    } bias_stage_t;

    typedef struct packed {
        logic                     vld;
        logic [OFM_DW-1:0]        data;
        meta_t                    meta;
    } out_stage_t;

    // One extra bit keeps the rounding add from wrapping before the shift.
    function automatic logic [7:0] requant_act(input logic signed [W_ACC-1:0] b,
                                               input logic [W_SHIFT-1:0] sh);
        logic signed [W_ACC:0] rnd;
        logic signed [W_ACC:0] t;
        rnd = (sh == '0) ? '0 : ((W_ACC+1)'(1) << (sh - W_SHIFT'(1)));
        t = $signed({b[W_ACC-1], b}) + rnd;
        t = t >>> sh;
        if (t[W_ACC]) begin
`ifdef PSUM_POSTPROC_LEAKY_EN
            t = t >>> 3;
`else
            t = '0;
`endif
        end
        if (t > $signed((W_ACC+1)'(127)))
            return 8'h7f;
        if (t < -$signed((W_ACC+1)'(128)))
            return 8'h80;
        return t[7:0];
    endfunction

endpackage

// File: rtl/psum_postproc_if.sv
// rtl/psum_postproc_if.sv - PE-engine input word and OFM output word bundle
interface psum_postproc_if;
    import psum_postproc_pkg::*;

    logic                    pe_vld;
    logic [Tout*W_PSUM-1:0]  pe_data;
    logic [W_SIZE-1:0]       pe_row;
    logic [W_SIZE-1:0]       pe_col;
    logic [W_CHANNEL-1:0]    pe_chn;
    logic [W_CHANNEL-1:0]    pe_chn_out;
    logic                    pe_is_last_chn;

    logic                    o_ofm_vld;
    logic [OFM_DW-1:0]       o_ofm_data;
    logic [W_SIZE-1:0]       o_ofm_row;
    logic [W_SIZE-1:0]       o_ofm_col;
    logic [W_CHANNEL-1:0]    o_ofm_chn_out;

    modport master (
        output pe_vld, pe_data, pe_row, pe_col, pe_chn, pe_chn_out, pe_is_last_chn,
        input  o_ofm_vld, o_ofm_data, o_ofm_row, o_ofm_col, o_ofm_chn_out
    );

    modport slave (
        input  pe_vld, pe_data, pe_row, pe_col, pe_chn, pe_chn_out, pe_is_last_chn,
        output o_ofm_vld, o_ofm_data, o_ofm_row, o_ofm_col, o_ofm_chn_out
    );

endinterface

// File: rtl/psum_postproc_psum_ram.sv
// rtl/psum_postproc_psum_ram.sv - simple dual-port psum memory, one write port, one synchronous read port
module psum_ram
    import psum_postproc_pkg::*;
#(
    parameter int DW    = Tout * W_ACC,
    parameter int AW    = PSUM_AW,
    parameter int DEPTH = PSUM_DEPTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Write-first: a read colliding with this cycle's write sees the new value.
    always_comb begin
        rd_data_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/psum_postproc.sv
// rtl/psum_postproc.sv - psum accumulate, bias, requant, activation and int8 saturation pipeline
// PSUM_POSTPROC_LEAKY_EN selects leaky activation; undefined gives ReLU.
module psum_postproc
    import psum_postproc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SHIFT-1:0]      q_shift,
    input  logic [Tout*W_BIAS-1:0]  bias_flat,
    psum_postproc_if.slave          bus,
    output logic                    o_addr_ovf
);

    in_stage_t   s0_q, s0_d, s1_q, s1_d;
    acc_stage_t  s2_q, s2_d;
    bias_stage_t s3_q, s3_d;
    out_stage_t  out_q, out_d;
    logic        ovf_q, ovf_d;

    logic [W_ADDR_FULL-1:0]  addr_full;
    logic [Tout*W_ACC-1:0]   rd_data;
    logic [Tout*W_ACC-1:0]   acc_all;
    logic [Tout*W_ACC-1:0]   b_all;
    logic [OFM_DW-1:0]       q_all;
    logic                    ram_we;
    logic                    bypass;

    always_comb begin
        addr_full = W_ADDR_FULL'(bus.pe_row) * W_ADDR_FULL'(q_width) + W_ADDR_FULL'(bus.pe_col);
        s0_d      = s0_q;
        s0_d.vld  = bus.pe_vld;
        if (bus.pe_vld) begin
            s0_d.first        = (bus.pe_chn == '0);
            s0_d.last         = bus.pe_is_last_chn;
            s0_d.addr         = addr_full[PSUM_AW-1:0];
            s0_d.data         = bus.pe_data;
            s0_d.meta.row     = bus.pe_row;
            s0_d.meta.col     = bus.pe_col;
            s0_d.meta.chn_out = bus.pe_chn_out;
        end
        ovf_d = ovf_q | (bus.pe_vld & (addr_full >= W_ADDR_FULL'(PSUM_DEPTH)));
    end

    // Only non-last words are written back; last-tile words leave the memory untouched.
    assign ram_we = s2_q.vld & ~s2_q.last;
    assign bypass = ram_we & (s2_q.addr == s1_q.addr);

    psum_ram #(
        .DW    (Tout * W_ACC),
        .AW    (PSUM_AW),
        .DEPTH (PSUM_DEPTH)
    ) u_psum_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (s2_q.addr),
        .wdata   (s2_q.acc),
        .raddr   (s0_q.addr),
        .rd_data (rd_data)
    );

    for (genvar i = 0; i < Tout; i++) begin : g_lane
        logic signed [W_ACC-1:0] base;
        logic [W_PSUM-1:0]       psum;
        logic [W_BIAS-1:0]       bias;

        assign psum = s1_q.data[i*W_PSUM +: W_PSUM];
        assign bias = bias_flat[i*W_BIAS +: W_BIAS];

        always_comb begin
            if (s1_q.first)
                base = '0;
            else if (bypass)
                base = s2_q.acc[i*W_ACC +: W_ACC];
            else
                base = rd_data[i*W_ACC +: W_ACC];
        end

        assign acc_all[i*W_ACC +: W_ACC] = base + {{(W_ACC-W_PSUM){psum[W_PSUM-1]}}, psum};
        assign b_all[i*W_ACC +: W_ACC]   = s2_q.acc[i*W_ACC +: W_ACC]
                                         + {{(W_ACC-W_BIAS){bias[W_BIAS-1]}}, bias};
        assign q_all[i*8 +: 8]           = requant_act(s3_q.b[i*W_ACC +: W_ACC], q_shift);
    end

    always_comb begin
        s1_d       = s0_q;
        s2_d.vld   = s1_q.vld;
        s2_d.last  = s1_q.last;
        s2_d.addr  = s1_q.addr;
        s2_d.acc   = acc_all;
        s2_d.meta  = s1_q.meta;
        s3_d.vld   = s2_q.vld & s2_q.last;
        s3_d.b     = b_all;
        s3_d.meta  = s2_q.meta;
        out_d.vld  = s3_q.vld;
        out_d.data = q_all;
        out_d.meta = s3_q.meta;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            s0_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.o_ofm_vld     = out_q.vld;
    assign bus.o_ofm_data    = out_q.data;
    assign bus.o_ofm_row     = out_q.meta.row;
    assign bus.o_ofm_col     = out_q.meta.col;
    assign bus.o_ofm_chn_out = out_q.meta.chn_out;
    assign o_addr_ovf        = ovf_q;

endmodule

// File: tb/tb_psum_postproc.sv
// tb/tb_psum_postproc.sv - self-checking bench for psum_postproc (PSUM_POSTPROC_LEAKY_EN aware)
module tb_psum_postproc;
    import psum_postproc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [W_SIZE-1:0]      q_width;
    logic [W_SHIFT-1:0]     q_shift;
    logic [Tout*W_BIAS-1:0] bias_flat;
    logic                   o_addr_ovf;

    psum_postproc_if bus ();

    psum_postproc dut (
        .clk        (clk),
        .rstn       (rstn),
        .q_width    (q_width),
        .q_shift    (q_shift),
        .bias_flat  (bias_flat),
        .bus        (bus),
        .o_addr_ovf (o_addr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        int          chn_out;
        int          cyc;
    } exp_t;

    typedef struct {
        int          p[4];
        int          bias[4];
        int          sh;
        logic [31:0] exp_relu;
        logic [31:0] exp_leaky;
    } vec_t;

    exp_t exp_q[$];
    int   mm[512][4];
    int   cur_bias[4];
    int   cur_shift;
    int   q_width_i;
    bit   exp_ovf;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] ref_q(input int b, input int sh);
        longint r;
        r = longint'(b);
        if (sh > 0)
            r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (r < 0) begin
`ifdef PSUM_POSTPROC_LEAKY_EN
            r = r >>> 3;
`else
            r = 0;
`endif
        end
        if (r > 127)
            r = 127;
        else if (r < -128)
            r = -128;
        return r[7:0];
    endfunction

    function automatic int rnd_signed(input int bits);
        int v;
        v = int'($urandom);
        return (v <<< (32 - bits)) >>> (32 - bits);
    endfunction

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2, input int b3,
                                input int sh, input logic [31:0] er, input logic [31:0] el);
        vec_t v;
        v.p[0] = a0; v.p[1] = a1; v.p[2] = a2; v.p[3] = a3;
        v.bias[0] = b0; v.bias[1] = b1; v.bias[2] = b2; v.bias[3] = b3;
        v.sh = sh;
        v.exp_relu = er;
        v.exp_leaky = el;
        return v;
    endfunction

    task automatic set_cfg(input int qw, input int b0, input int b1, input int b2, input int b3,
                           input int sh);
        q_width_i   = qw;
        q_width     = W_SIZE'(qw);
        cur_bias[0] = b0; cur_bias[1] = b1; cur_bias[2] = b2; cur_bias[3] = b3;
        cur_shift   = sh;
        q_shift     = W_SHIFT'(sh);
        bias_flat   = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    endtask

    task automatic idle();
        bus.pe_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int row, input int col, input int chn, input int chn_out,
                        input bit last, input int p0, input int p1, input int p2, input int p3,
                        input bit use_exp, input logic [31:0] exp_data, input bit track);
        int     p[4];
        longint full;
        int     addr;
        int     acc;
        exp_t   e;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        full = longint'(row) * longint'(q_width_i) + longint'(col);
        addr = int'(full % 512);
        if (full >= 512)
            exp_ovf = 1'b1;
        e.data = '0;
        for (int l = 0; l < 4; l++) begin
            acc = ((chn == 0) ? 0 : mm[addr][l]) + p[l];
            if (!last)
                mm[addr][l] = acc;
            else
                e.data[l*8 +: 8] = ref_q(acc + cur_bias[l], cur_shift);
        end
        if (use_exp)
            e.data = exp_data;
        e.row = row; e.col = col; e.chn_out = chn_out; e.cyc = cyc + 5;
        if (last && track)
            exp_q.push_back(e);
        bus.pe_vld         = 1'b1;
        bus.pe_data        = {p3[19:0], p2[19:0], p1[19:0], p0[19:0]};
        bus.pe_row         = W_SIZE'(row);
        bus.pe_col         = W_SIZE'(col);
        bus.pe_chn         = W_CHANNEL'(chn);
        bus.pe_chn_out     = W_CHANNEL'(chn_out);
        bus.pe_is_last_chn = last;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.pe_vld = 1'b0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        check("addr_ovf", 64'(o_addr_ovf), 64'(exp_ovf));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"}, 64'(bus.o_ofm_vld), 64'd0);
        check({tag, "_data"}, 64'(bus.o_ofm_data), 64'd0);
        check({tag, "_row"}, 64'(bus.o_ofm_row), 64'd0);
        check({tag, "_col"}, 64'(bus.o_ofm_col), 64'd0);
        check({tag, "_chn_out"}, 64'(bus.o_ofm_chn_out), 64'd0);
        check({tag, "_ovf"}, 64'(o_addr_ovf), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_ofm_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ofm_data", 64'(bus.o_ofm_data), 64'(e.data));
                check("ofm_meta", 64'({bus.o_ofm_row, bus.o_ofm_col, bus.o_ofm_chn_out}),
                      64'({9'(e.row), 9'(e.col), 9'(e.chn_out)}));
                check("ofm_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[4];
        logic [31:0] ev;

        tbl[0] = mk(10, -20, 300, 0, 5, 5, 5, 5, 1, 32'h037F0008, 32'h037FFF08);
        tbl[1] = mk(-40, -2000, 127, 128, 0, 0, 0, 0, 0, 32'h7F7F0000, 32'h7F7F80FB);
        tbl[2] = mk(6, 5, -6, -7, 0, 0, 0, 0, 2, 32'h00000102, 32'hFFFF0102);
        tbl[3] = mk(524287, -524288, 1000, -1, -32768, 32767, 0, 1, 4, 32'h003F007F, 32'h003F807F);

        rstn               = 1'b1;
        exp_ovf            = 1'b0;
        bus.pe_vld         = 1'b0;
        bus.pe_data        = '0;
        bus.pe_row         = '0;
        bus.pe_col         = '0;
        bus.pe_chn         = '0;
        bus.pe_chn_out     = '0;
        bus.pe_is_last_chn = 1'b0;
        set_cfg(4, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        check_zero_outputs("reset");

        // Single-tile requant/activation vectors
        for (int i = 0; i < 4; i++) begin
            set_cfg(4, tbl[i].bias[0], tbl[i].bias[1], tbl[i].bias[2], tbl[i].bias[3], tbl[i].sh);
`ifdef PSUM_POSTPROC_LEAKY_EN
            ev = tbl[i].exp_leaky;
`else
            ev = tbl[i].exp_relu;
`endif
            send(0, i, 0, i + 1, 1'b1, tbl[i].p[0], tbl[i].p[1], tbl[i].p[2], tbl[i].p[3],
                 1'b1, ev, 1'b1);
            drain();
        end

        // Two tiles over a 4x4 tile, raster order
        set_cfg(4, 0, 0, 0, 0, 2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(r, c, 0, 3, 1'b0, 100, 100, 100, 100, 1'b0, '0, 1'b1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send(r, c, 1, 3, 1'b1, 28, 28, 28, 28, 1'b1, 32'h20202020, 1'b1);
        drain();

        // Back-to-back hits on a single-pixel tile
        set_cfg(1, 0, 0, 0, 0, 0);
        send(0, 0, 0, 9, 1'b0, 1, 1, 1, 1, 1'b0, '0, 1'b1);
        send(0, 0, 1, 9, 1'b0, 1, 1, 1, 1, 1'b0, '0, 1'b1);
        send(0, 0, 2, 9, 1'b1, 1, 1, 1, 1, 1'b1, 32'h03030303, 1'b1);
        drain();

        // Randomized traffic against the reference model
        for (int round = 0; round < 6; round++) begin
            set_cfg(4, rnd_signed(16), rnd_signed(16), rnd_signed(16), rnd_signed(16),
                    int'($urandom_range(10)));
            for (int a = 0; a < 8; a++)
                send(a / 4, a % 4, 0, 0, 1'b0, rnd_signed(20), rnd_signed(20), rnd_signed(20),
                     rnd_signed(20), 1'b0, '0, 1'b1);
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(3) != 0)
                    send(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
                         int'($urandom_range(511)), ($urandom_range(2) == 0),
                         rnd_signed(20), rnd_signed(20), rnd_signed(20), rnd_signed(20),
                         1'b0, '0, 1'b1);
                else
                    idle();
            end
            drain();
        end

        // Address overflow: invalid words never flag, a valid one sets it sticky
        set_cfg(16, 0, 0, 0, 0, 0);
        bus.pe_row = 9'd40;
        bus.pe_col = 9'd0;
        idle();
        idle();
        check("ovf_idle", 64'(o_addr_ovf), 64'd0);
        send(40, 0, 0, 7, 1'b1, 1, 2, 3, 4, 1'b0, '0, 1'b1);
        check("ovf_rise", 64'(o_addr_ovf), 64'd1);
        repeat (3) idle();
        check("ovf_sticky", 64'(o_addr_ovf), 64'd1);
        drain();

        // Reset while two last-tile words sit in S2/S3
        set_cfg(4, 0, 0, 0, 0, 0);
        send(0, 1, 0, 5, 1'b1, 50, 50, 50, 50, 1'b0, '0, 1'b0);
        send(0, 2, 0, 5, 1'b1, 60, 60, 60, 60, 1'b0, '0, 1'b0);
        idle();
        idle();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        exp_ovf = 1'b0;
        check_zero_outputs("midreset");
        repeat (10) idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
